load_unit: RTL
==============

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before a fault response.
REQ-002 SHALL have port clk, input, 1, the single system clock (all state on rising edge).
REQ-003 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, meaning a load request is present.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit accepts a request (IDLE only).
REQ-006 SHALL have port req_addr, input, 32, the byte address.
REQ-007 SHALL have port req_funct3, input, 3, the RV32I load encoding.
REQ-008 SHALL have port mem_req, output, 1, the data-memory read request.
REQ-009 SHALL have port mem_addr, output, 32, the word-aligned address {addr[31:2],2'b00}.
REQ-010 SHALL have port mem_gnt, input, 1, meaning memory accepted mem_req.
REQ-011 SHALL have port mem_rvalid, input, 1, meaning mem_rdata is valid.
REQ-012 SHALL have port mem_rdata, input, 32, the read word.
REQ-013 SHALL have port rsp_valid, output, 1, meaning a response is held.
REQ-014 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-015 SHALL have port rsp_data, output, 32, the aligned, extended result.
REQ-016 SHALL have port rsp_fault, output, 1, meaning an illegal, misaligned or timed-out load.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with one request in flight and no back-to-back acceptance.
REQ-018 IDLE: req_ready=1; on req_valid, capture addr/funct3 -> ISSUE (legal), or RESP with fault=1, data=0 and no memory access (illegal or trapped misaligned).
REQ-019 ISSUE: mem_req=1 and mem_addr stable until mem_gnt is sampled high -> WAIT.
REQ-020 WAIT: mem_rvalid is sampled only in WAIT, and rvalid arriving with gnt in ISSUE is ignored; rvalid -> capture extracted data, fault=0 -> RESP.
REQ-021 WAIT: the counter increments each cycle and clears on entry; on reaching TIMEOUT_CYCLES without rvalid -> RESP with fault=1, data=0.
REQ-022 RESP: rsp_valid=1 with rsp_data/rsp_fault held stable until rsp_ready -> IDLE.
REQ-023 Minimum latency: accepted at edge E0, gnt at E1, rvalid at E2, rsp_valid high after E2.
REQ-024 funct3 decode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
REQ-025 Byte loads: byte = rdata[8*addr[1:0]+:8]; LB sign-extends, LBU zero-extends.
REQ-026 Half loads: half = addr[1] ? rdata[31:16] : rdata[15:0]; LH sign-extends, LHU zero-extends.
REQ-027 LW: rsp_data = rdata.
REQ-028 A misaligned load is LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.

Reset
REQ-029 rst SHALL force state=IDLE, with mem_req=0, rsp_valid=0, rsp_fault=0, rsp_data=0, counter=0 and req_ready=1 after release.
REQ-030 Reset mid-operation SHALL abandon the transaction immediately, ignoring a later mem_rvalid and emitting no response.

Configuration
REQ-031 With macro LOAD_MISALIGN_TRAP_EN defined, misaligned loads SHALL respond fault=1, data=0 and never assert mem_req.
REQ-032 Without LOAD_MISALIGN_TRAP_EN, misaligned loads SHALL proceed normally: LH/LHU ignores addr[0], LW ignores addr[1:0], and fault is never set for misalignment.

Structure
REQ-033 Package load_pkg SHALL hold the funct3 constants, the FSM state typedef and the misalignment-check function.
REQ-034 Combinational sub-module load_align SHALL perform lane select and extension (inputs rdata, offset, funct3); the FSM and counter stay in load_unit.

Verification
REQ-035 Scenario: rdata=32'h8899AABB, LB at 0x1003 -> rsp_data=32'hFFFFFF88, fault=0, mem_addr=32'h1000.
REQ-036 Scenario: same rdata, LBU 0x1001 -> 32'h000000AA; LHU 0x1002 -> 32'h00008899; LH 0x1000 -> 32'hFFFFAABB.
REQ-037 Scenario: LW at 0x1002 with macro -> fault=1, data=0, mem_req never high; without macro -> 32'h8899AABB.
REQ-038 Scenario: TIMEOUT_CYCLES=4, gnt given, rvalid never -> rsp_valid with fault=1 after 4 WAIT cycles; funct3=3'b011 -> fault with no mem_req.
REQ-039 Scenario: rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable and req_ready=0 throughout; gnt delayed 3 cycles -> mem_addr stable.
REQ-040 Scenario: rst pulsed in WAIT, then rvalid -> mem_req=0, rsp_valid stays 0, req_ready=1.

Source files
------------

// File: rtl/load_pkg.sv
// ============================================================================
// Module  : load_pkg
// Brief   : funct3 constants, FSM state type and legality/alignment helpers
//           for the RV32I load unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package load_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 == c_F3_LB) || (f3 == c_F3_LH) || (f3 == c_F3_LW) ||
               (f3 == c_F3_LBU) || (f3 == c_F3_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (((f3 == c_F3_LH) || (f3 == c_F3_LHU)) && off[0]) ||
               ((f3 == c_F3_LW) && (off != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module  : load_align
// Brief   : Combinational lane select and sign/zero extension of a read word.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module load_align
    import load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        // offset[0] is deliberately ignored for halfwords
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = 32'h0;
        case (funct3)
            c_F3_LB:  data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: data = {24'h0, w_byte};
            c_F3_LH:  data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: data = {16'h0, w_half};
            c_F3_LW:  data = rdata;
            default:  data = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_unit.sv
// ============================================================================
// Module  : load_unit
// Brief   : Single-outstanding RV32I load unit with memory timeout. Define
//           LOAD_MISALIGN_TRAP_EN to fault misaligned loads without access.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              fault_q, fault_d;
    logic [31:0]       w_aligned;
    logic              w_reject;

    load_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (w_aligned)
    );

    // Requests that must fault immediately without touching memory
`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_reject = !f3_is_legal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_reject = !f3_is_legal(req_funct3);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    f3_d   = req_funct3;
                    if (w_reject) begin
                        data_d  = 32'h0;
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    data_d  = w_aligned;
                    fault_d = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == c_CNT_LAST) begin
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            f3_q    <= 3'b000;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = data_q;
    assign rsp_fault = fault_q;

endmodule

`default_nettype wire
